bus_timer: RTL and testbench
============================

# bus_timer

Memory-mapped 32-bit timer that is a responder on the CPU data bus, beside the data RAM. It decodes the CPU's bus address, write-enable, write-data and store-width signals. It returns read data combinationally, as the RAM does. It runs a prescaled up-counter with compare/reload, one-shot or auto-reload modes, and a sticky match flag that drives an interrupt line.

## Interface
- `PSC_W`, default 16: prescaler register width; upper bits of the PSC word read as 0.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset; 0 clears all state immediately.
- `sel` input 1: chip select from the top-level address decoder; writes are ignored when low.
- `we` input 1: bus write enable; a write commits at the clock edge when `sel && we`.
- `addr` input 32: bus byte address; only `addr[4:0]` is decoded.
- `wData` input 32: bus write data, register-aligned as the CPU drives it.
- `func3` input 3: store width; 000 = byte, 001 = halfword, 010 = word; other codes are ignored, with no write.
- `rData` output 32: read data, combinational from `addr` and the current register state.
- `irq` output 1: `STATUS.MATCH & CTRL.IRQ_EN`, driven from registers.

## Operation
- Register map, by word offset:
  - 0x00 CTRL: bit0 EN, bit1 AUTO, bit2 IRQ_EN, bit3 CLR. CLR is write-only, self-clearing and reads 0.
  - 0x04 PSC: prescale divisor minus 1.
  - 0x08 ARR: compare/reload value.
  - 0x0C CNT: counter, read/write.
  - 0x10 STATUS: bit0 MATCH, write-1-to-clear.
  - Offsets 0x14–0x1C read 0; writes to them are ignored.
- Byte lanes for writes:
  - Byte store writes lane `addr[1:0]`.
  - Halfword store writes lanes `{addr[1],0}` and `{addr[1],1}`.
  - Word store writes all four lanes.
  - Misaligned halfword/word stores are ignored.
- Reads always return the full aligned word and ignore `func3`. Software uses `lw`.
- Prescaler: while EN=1, `psc_cnt` increments each cycle. When `psc_cnt == PSC` it returns to 0 and pulses `tick` for one cycle.
- Behaviour on `tick`:
  - If CNT == ARR: CNT ← 0 and MATCH ← 1. If AUTO=0, EN ← 0 (one-shot).
  - Otherwise CNT ← CNT + 1, modulo 2^32.
- EN=0 freezes both CNT and `psc_cnt`.
- Boundary rules:
  - A bus write to CNT and a `tick` in the same cycle: the bus value wins and the tick is dropped.
  - A CLR write clears CNT and `psc_cnt` in that cycle. This overrides a tick and any CNT write.
  - A write to PSC also clears `psc_cnt`.
  - A W1C to MATCH and a hardware set in the same cycle: the set wins, so MATCH stays 1.
  - ARR=0: MATCH is set on every tick.
  - ARR written below the current CNT: the counter runs up to 2^32−1 and wraps to 0 without setting MATCH, then matches normally.
  - A CTRL write that sets EN while a one-shot completes in the same cycle: the bus value of EN wins.
  - Reset asserted mid-count: all registers go to 0 immediately, and the counter does not resume after release.
- Reset values: CTRL, PSC, ARR, CNT, STATUS, `psc_cnt` = 0, so `irq` = 0. `rData` reflects the zeroed registers.

## Timing
- Write latency: a register is updated at the edge where `sel && we` is sampled. A read in the next cycle returns the new value.
- Read latency: 0 cycles (combinational), the same as the RAM.
- Count latency: after the edge that sets EN=1 (edge E0), the first tick occurs at E0+PSC+1. CNT therefore first reads 1 after that edge.
- Worked example, PSC=0, ARR=3, AUTO=1: CNT sequence after E0 is 1, 2, 3, 0, 1, … MATCH and `irq` rise after edge E4.
- `irq` is level-sensitive and stays high until MATCH is cleared or IRQ_EN is cleared.

## Structure
- Shared package `bus_pkg` holds:
  - the `func3` store-width codes (shared with the RAM);
  - the timer register offsets;
  - the CTRL/STATUS bit indices;
  - a `byte_en` function that maps `func3` and `addr[1:0]` to a 4-bit lane mask.
- One sub-module, `timer_prescaler`:
  - inputs: `clk`, `reset`, `en`, `clr`, `psc`;
  - output: `tick`.
- Register file, counter/compare logic and read mux stay in `bus_timer`.

## Test plan
- Reset with `reset`=0 mid-count, then release → all reads 0 and `irq`=0. CNT stays 0 for 10 cycles.
- PSC=0, ARR=3, CTRL=0b111 → CNT is 1, 2, 3, 0, 1 on successive cycles. `irq`=1 from the cycle after the wrap. Writing STATUS=1 drops `irq` the next cycle.
- PSC=4, ARR=2, CTRL=EN only (one-shot) → CNT increments every 5 cycles. MATCH is set after 15 cycles, EN reads 0, and CNT stays 0.
- `sb` of 0xAB to offset 0x09 with ARR=0 → ARR reads 0x0000AB00. `sh` to offset 0x09 → ARR unchanged.
- Bus write CNT=100 coinciding with a tick → CNT reads 100, not 101. W1C to STATUS in the same cycle as a match → MATCH stays 1.
- ARR=5 with CNT written to 10, running → no MATCH until CNT wraps past 0xFFFFFFFF. MATCH is then set when CNT reaches 5.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared CPU data-bus definitions: store-width codes, timer register map and
// the byte-lane decoder used by every bus responder.
package bus_pkg;

    typedef enum logic [2:0] {
        F3_BYTE = 3'b000,
        F3_HALF = 3'b001,
        F3_WORD = 3'b010
    } store_width_e;

    // Timer registers by word index (byte offset >> 2)
    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_PSC    = 3'd1,
        REG_ARR    = 3'd2,
        REG_CNT    = 3'd3,
        REG_STATUS = 3'd4
    } timer_reg_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_AUTO    = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned CTRL_CLR     = 3;
    localparam int unsigned STATUS_MATCH = 0;

    // Misaligned or unknown store widths yield an empty mask, i.e. no write.
    function automatic logic [3:0] byte_en(input logic [2:0] func3, input logic [1:0] lane);
        case (func3)
            F3_BYTE: return 4'b0001 << lane;
            F3_HALF: return lane[0] ? 4'b0000 : (lane[1] ? 4'b1100 : 4'b0011);
            F3_WORD: return (lane == 2'b00) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for bus_timer: emits a one-cycle tick every psc+1 enabled cycles.
module timer_prescaler #(
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt;

    // A clear restarts the period, so the tick in that cycle is dropped.
    assign tick = en && !clr && (psc_cnt == psc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_cnt <= '0;
        end else if (clr) begin
            psc_cnt <= '0;
        end else if (en) begin
            psc_cnt <= (psc_cnt == psc) ? '0 : psc_cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer on the CPU data bus: prescaled up-counter with
// compare/reload, one-shot or auto-reload, sticky MATCH and level irq.
module bus_timer
    import bus_pkg::*;
#(
    parameter int PSC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    input  logic [2:0]  func3,
    output logic [31:0] rData,
    output logic        irq
);

    logic             en, auto_rl, irq_en, match;
    logic [PSC_W-1:0] psc;
    logic [31:0]      arr, cnt;

    logic [3:0]  be;
    logic [31:0] wmask, arr_new, cnt_new;
    logic [2:0]  widx;
    logic        wr_ctrl_lo, wr_psc, wr_arr, wr_cnt, w1c_match;
    logic        clr, tick, hw_tick, hit;
    logic        addr_unused;

    assign addr_unused = ^addr[31:5];

    always_comb begin
        be    = (sel && we) ? byte_en(func3, addr[1:0]) : 4'b0000;
        wmask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{be[i]}};
        end
        widx       = addr[4:2];
        wr_ctrl_lo = be[0] && (widx == REG_CTRL);
        wr_psc     = (be != 4'b0000) && (widx == REG_PSC);
        wr_arr     = (be != 4'b0000) && (widx == REG_ARR);
        wr_cnt     = (be != 4'b0000) && (widx == REG_CNT);
        w1c_match  = be[0] && (widx == REG_STATUS) && wData[STATUS_MATCH];
        clr        = wr_ctrl_lo && wData[CTRL_CLR];
        arr_new    = (arr & ~wmask) | (wData & wmask);
        cnt_new    = (cnt & ~wmask) | (wData & wmask);
        // A bus write to CNT or a clear swallows the tick entirely.
        hw_tick    = tick && !clr && !wr_cnt;
        hit        = hw_tick && (cnt == arr);
    end

    timer_prescaler #(
        .PSC_W(PSC_W)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clr  (clr || wr_psc),
        .psc  (psc),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            irq_en  <= 1'b0;
            match   <= 1'b0;
            psc     <= '0;
            arr     <= '0;
            cnt     <= '0;
        end else begin
            if (hit && !auto_rl) begin
                en <= 1'b0;
            end
            if (wr_ctrl_lo) begin
                en      <= wData[CTRL_EN];
                auto_rl <= wData[CTRL_AUTO];
                irq_en  <= wData[CTRL_IRQ_EN];
            end
            if (wr_psc) begin
                psc <= PSC_W'((32'(psc) & ~wmask) | (wData & wmask));
            end
            if (wr_arr) begin
                arr <= arr_new;
            end
            if (clr) begin
                cnt <= '0;
            end else if (wr_cnt) begin
                cnt <= cnt_new;
            end else if (hw_tick) begin
                cnt <= hit ? '0 : cnt + 32'd1;
            end
            if (w1c_match) begin
                match <= 1'b0;
            end
            if (hit) begin
                match <= 1'b1;
            end
        end
    end

    always_comb begin
        rData = '0;
        case (widx)
            REG_CTRL:   rData = {29'b0, irq_en, auto_rl, en};
            REG_PSC:    rData = 32'(psc);
            REG_ARR:    rData = arr;
            REG_CNT:    rData = cnt;
            REG_STATUS: rData = {31'b0, match};
            default:    rData = '0;
        endcase
    end

    assign irq = match && irq_en;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: register-level model compared every cycle
// plus directed scenarios with hand-computed expected values.
module tb_bus_timer;

    localparam int PSC_W = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        sel   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wData = '0;
    logic [2:0]  func3 = 3'd2;
    logic [31:0] rData;
    logic        irq;

    int errors = 0;
    int checks = 0;

    bus_timer #(.PSC_W(PSC_W)) dut (
        .clk  (clk),
        .reset(reset),
        .sel  (sel),
        .we   (we),
        .addr (addr),
        .wData(wData),
        .func3(func3),
        .rData(rData),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    // ---------------- architectural model ----------------
    bit          m_en = 0, m_auto = 0, m_ie = 0, m_match = 0;
    logic [31:0] m_psc = '0, m_arr = '0, m_cnt = '0, m_pc = '0;

    function automatic logic [3:0] lanes_of(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'd0) return 4'b0001 << a;
        if (f3 == 3'd1 && a == 2'd0) return 4'b0011;
        if (f3 == 3'd1 && a == 2'd2) return 4'b1100;
        if (f3 == 3'd2 && a == 2'd0) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] ln);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (ln[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[4:2])
            3'd0:    return {29'b0, m_ie, m_auto, m_en};
            3'd1:    return m_psc;
            3'd2:    return m_arr;
            3'd3:    return m_cnt;
            3'd4:    return {31'b0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] ln;
        int         off;
        bit         any, w_ctrl, w_psc, w_arr, w_cnt, w_st, clr, tk, hit;
        ln     = (sel && we) ? lanes_of(func3, addr[1:0]) : 4'b0000;
        off    = int'(addr[4:2]);
        any    = (ln != 4'b0000);
        w_ctrl = any && off == 0 && ln[0];
        w_psc  = any && off == 1;
        w_arr  = any && off == 2;
        w_cnt  = any && off == 3;
        w_st   = any && off == 4 && ln[0];
        clr    = w_ctrl && wData[3];
        tk     = m_en && (m_pc == m_psc) && !clr && !w_cnt && !w_psc;
        hit    = tk && (m_cnt == m_arr);

        if (clr || w_psc) m_pc = 0;
        else if (m_en) m_pc = (m_pc == m_psc) ? 0 : m_pc + 1;

        if (clr) m_cnt = 0;
        else if (w_cnt) m_cnt = merge(m_cnt, wData, ln);
        else if (tk) m_cnt = hit ? 0 : m_cnt + 1;

        if (hit && !m_auto) m_en = 0;
        if (w_ctrl) begin
            m_en   = wData[0];
            m_auto = wData[1];
            m_ie   = wData[2];
        end
        if (w_psc) m_psc = merge(m_psc, wData, ln) & 32'h0000_FFFF;
        if (w_arr) m_arr = merge(m_arr, wData, ln);
        if (w_st && wData[0]) m_match = 0;
        if (hit) m_match = 1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_en = 0; m_auto = 0; m_ie = 0; m_match = 0;
            m_psc = 0; m_arr = 0; m_cnt = 0; m_pc = 0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks++;
        if (rData !== m_read(addr)) begin
            errors++;
            $display("FAIL model_rdata @%0t addr=%h got=%h exp=%h", $time, addr, rData, m_read(addr));
        end
        checks++;
        if (irq !== (m_match && m_ie)) begin
            errors++;
            $display("FAIL model_irq @%0t got=%b exp=%b", $time, irq, m_match && m_ie);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        sel = 1'b1; we = 1'b1; addr = a; wData = d; func3 = f3;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        checks++;
        if (rData !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", name, rData, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic exp);
        checks++;
        if (irq !== exp) begin
            errors++;
            $display("FAIL %s: got %b exp %b", name, irq, exp);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #21 reset = 1'b1;
        idle(1);
        chk("rst_ctrl", 32'h00, 32'd0);
        chk("rst_cnt", 32'h0C, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // Worked example: PSC=0, ARR=3, EN|AUTO|IRQ_EN
        wr(32'h04, 32'd0, 3'd2);
        wr(32'h08, 32'd3, 3'd2);
        wr(32'h00, 32'd7, 3'd2);
        chk("a_cnt_e0", 32'h0C, 32'd0);
        idle(1); chk("a_cnt_1", 32'h0C, 32'd1);
        idle(1); chk("a_cnt_2", 32'h0C, 32'd2);
        idle(1); chk("a_cnt_3", 32'h0C, 32'd3); chk_irq("a_irq_pre", 1'b0);
        idle(1); chk("a_cnt_wrap", 32'h0C, 32'd0); chk_irq("a_irq_set", 1'b1);
        idle(1); chk("a_cnt_again", 32'h0C, 32'd1);
        wr(32'h10, 32'd1, 3'd2);
        chk_irq("a_irq_w1c", 1'b0);
        chk("a_status_w1c", 32'h10, 32'd0);
        wr(32'h00, 32'd0, 3'd2);
        idle(3); chk("a_cnt_frozen", 32'h0C, 32'd3);

        // One-shot: PSC=4, ARR=2
        wr(32'h00, 32'h8, 3'd2);
        wr(32'h04, 32'd4, 3'd2);
        wr(32'h08, 32'd2, 3'd2);
        wr(32'h00, 32'd1, 3'd2);
        idle(4);  chk("b_cnt_e4", 32'h0C, 32'd0);
        idle(1);  chk("b_cnt_e5", 32'h0C, 32'd1);
        idle(9);  chk("b_cnt_e14", 32'h0C, 32'd2);
        idle(1);  chk("b_cnt_e15", 32'h0C, 32'd0);
        chk("b_status", 32'h10, 32'd1);
        chk("b_ctrl_en_off", 32'h00, 32'd0);
        idle(10); chk("b_cnt_stays", 32'h0C, 32'd0);

        // Byte lanes and ignored stores
        wr(32'h08, 32'd0, 3'd2);
        wr(32'h09, 32'h0000_AB00, 3'd0);
        chk("c_sb_lane1", 32'h08, 32'h0000_AB00);
        wr(32'h09, 32'hFFFF_FFFF, 3'd1);
        chk("c_sh_misaligned", 32'h08, 32'h0000_AB00);
        wr(32'h0A, 32'h1234_0000, 3'd1);
        chk("c_sh_upper", 32'h08, 32'h1234_AB00);
        wr(32'h0A, 32'hFFFF_FFFF, 3'd2);
        wr(32'h08, 32'hFFFF_FFFF, 3'd3);
        chk("c_ignored", 32'h08, 32'h1234_AB00);
        wr(32'h14, 32'hFFFF_FFFF, 3'd2);
        chk("c_reserved", 32'h14, 32'd0);
        wr(32'h04, 32'hFFFF_1234, 3'd2);
        chk("c_psc_width", 32'h04, 32'h0000_1234);

        // CNT write vs tick, W1C vs match set
        wr(32'h10, 32'd1, 3'd2);
        chk("d_status_clr", 32'h10, 32'd0);
        wr(32'h04, 32'd0, 3'd2);
        wr(32'h08, 32'd1000, 3'd2);
        wr(32'h00, 32'd3, 3'd2);
        idle(2); chk("d_cnt_run", 32'h0C, 32'd2);
        wr(32'h0C, 32'd100, 3'd2);
        chk("d_cnt_bus_wins", 32'h0C, 32'd100);
        wr(32'h08, 32'd103, 3'd2);
        idle(2); chk("d_cnt_103", 32'h0C, 32'd103);
        wr(32'h10, 32'd1, 3'd2);
        chk("d_set_beats_w1c", 32'h10, 32'd1);
        chk("d_cnt_reload", 32'h0C, 32'd0);

        // ARR below CNT: wrap through 2^32-1 without match
        wr(32'h00, 32'h8, 3'd2);
        wr(32'h10, 32'd1, 3'd2);
        wr(32'h08, 32'd5, 3'd2);
        wr(32'h0C, 32'hFFFF_FFFC, 3'd2);
        wr(32'h00, 32'd3, 3'd2);
        chk("e_cnt_start", 32'h0C, 32'hFFFF_FFFC);
        idle(3); chk("e_cnt_max", 32'h0C, 32'hFFFF_FFFF);
        idle(1); chk("e_cnt_wrap", 32'h0C, 32'd0);
        chk("e_no_match_wrap", 32'h10, 32'd0);
        idle(5); chk("e_cnt_5", 32'h0C, 32'd5);
        chk("e_no_match_yet", 32'h10, 32'd0);
        idle(1); chk("e_match", 32'h10, 32'd1);

        // CTRL write setting EN on the one-shot completion edge
        wr(32'h00, 32'h8, 3'd2);
        wr(32'h10, 32'd1, 3'd2);
        wr(32'h08, 32'd2, 3'd2);
        wr(32'h00, 32'd1, 3'd2);
        idle(2);
        wr(32'h00, 32'd1, 3'd2);
        chk("f_en_bus_wins", 32'h00, 32'd1);
        chk("f_cnt_reload", 32'h0C, 32'd0);
        chk("f_match", 32'h10, 32'd1);
        idle(1); chk("f_cnt_continues", 32'h0C, 32'd1);

        // Reset mid-count
        wr(32'h00, 32'd7, 3'd2);
        chk_irq("g_irq_before", 1'b1);
        idle(2);
        #2 reset = 1'b0;
        chk("g_cnt_in_reset", 32'h0C, 32'd0);
        chk_irq("g_irq_in_reset", 1'b0);
        idle(2);
        #2 reset = 1'b1;
        idle(10);
        chk("g_cnt_after", 32'h0C, 32'd0);
        chk("g_ctrl_after", 32'h00, 32'd0);
        chk("g_arr_after", 32'h08, 32'd0);
        chk("g_psc_after", 32'h04, 32'd0);
        chk("g_status_after", 32'h10, 32'd0);
        chk_irq("g_irq_after", 1'b0);

        idle(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
